// File: rtl/mmio_hub_if.sv
// CPU-side MMIO bus for mmio_hub: address/data/strobes from the CPU,
// with the decode hit and combinational read data coming back.
interface mmio_hub_if;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        we;
  logic        rd_en;
  logic        hit;
  logic [31:0] rd;

  modport master (output addr, wd, we, rd_en, input hit, rd);
  modport slave  (input addr, wd, we, rd_en, output hit, rd);
endinterface

// File: rtl/mmio_hub.sv
// MMIO hub: keyboard scancode FIFO with STATUS/KBDATA/CTRL registers plus tile registers.
// Optional keyboard interrupt enabled by defining MMIO_HUB_IRQ_EN.
module mmio_hub #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          N_TILES    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_hub_if.slave              bus,
  input  logic                   kb_valid,
  input  logic [7:0]             kb_data,
  output logic [13*N_TILES-1:0]  tiles,
  output logic                   irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [29:0] W_STATUS = 30'd0;
  localparam logic [29:0] W_KBDATA = 30'd1;
  localparam logic [29:0] W_CTRL   = 30'd2;
  localparam logic [29:0] W_TILE0  = 30'd4;

  logic [29:0]   word;
  logic          hit;
  logic [31:0]   rd_data;
  logic [31:0]   ctrl_rd;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [12:0]   tile_q [N_TILES];
  logic [12:0]   tile_d [N_TILES];

  logic empty, full, pop, do_push, ctrl_wr, flush, clr_ovf;
  logic unused_wd;

  // Word offset into the window; the address below BASE wraps to a huge value and misses.
  assign word = bus.addr[31:2] - BASE_ADDR[31:2];
  assign hit  = word < (W_TILE0 + 30'(N_TILES));

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = bus.rd_en && hit && (word == W_KBDATA) && !empty;
  assign ctrl_wr = bus.we && hit && (word == W_CTRL);
  assign flush   = ctrl_wr && bus.wd[1];
  assign clr_ovf = ctrl_wr && bus.wd[0];

  assign unused_wd = ^bus.wd[31:13];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    do_push  = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
      do_push = kb_valid && (!full || pop);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(pop);
    end
    if (clr_ovf) ovf_d = 1'b0;
    if (kb_valid && full && !pop && !flush) ovf_d = 1'b1;
  end

  always_comb begin
    tile_d = tile_q;
    if (bus.we && hit) begin
      for (int i = 0; i < N_TILES; i++) begin
        if (word == W_TILE0 + 30'(i)) tile_d[i] = bus.wd[12:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (word)
        W_STATUS: rd_data = {16'b0, 8'(count_q), 5'b0, ovf_q, full, !empty};
        W_KBDATA: if (!empty) rd_data = {24'b0, mem_q[rd_ptr_q]};
        W_CTRL:   rd_data = ctrl_rd;
        default: begin
          for (int i = 0; i < N_TILES; i++) begin
            if (word == W_TILE0 + 30'(i)) rd_data = {19'b0, tile_q[i]};
          end
        end
      endcase
    end
  end

  assign bus.hit = hit;
  assign bus.rd  = rd_data;

  always_comb begin
    for (int i = 0; i < N_TILES; i++) tiles[13*i +: 13] = tile_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < N_TILES; i++) tile_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tile_q   <= tile_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= kb_data;
  end

`ifdef MMIO_HUB_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = ctrl_wr ? bus.wd[2] : irq_en_q;
    irq_d    = irq_en_q && !empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign ctrl_rd = {29'b0, irq_en_q, 2'b0};
  assign irq     = irq_q;
`else
  assign ctrl_rd = '0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_hub.sv
// Directed self-checking bench for mmio_hub (default parameters); IRQ steps run when
// MMIO_HUB_IRQ_EN is defined.
module tb_mmio_hub;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int DEPTH = 8;
  localparam int NT = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            kb_valid;
  logic [7:0]      kb_data;
  logic [13*NT-1:0] tiles;
  logic            irq;

  int checks = 0;
  int failures = 0;

  mmio_hub_if bus ();

  mmio_hub #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .N_TILES(NT)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .tiles    (tiles),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int c, input bit o);
    return {16'b0, 8'(c), 5'b0, o, c == DEPTH, c != 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.wd   = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    kb_valid = 1'b1;
    kb_data  = b;
    tick();
    kb_valid = 1'b0;
  endtask

  task automatic pop(output logic [31:0] d);
    bus.addr  = BASE + 32'h4;
    bus.rd_en = 1'b1;
    #1;
    d = bus.rd;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag, input int c, input bit o);
    logic [31:0] d;
    rd_reg(BASE, d);
    check(tag, 64'(d), 64'(st(c, o)));
  endtask

  initial begin
    logic [31:0] d;
    reset     = 1'b1;
    kb_valid  = 1'b0;
    kb_data   = '0;
    bus.addr  = BASE;
    bus.wd    = '0;
    bus.we    = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_status("reset_status", 0, 0);
    check("reset_hit", 64'(bus.hit), 64'(1));
    check("reset_tiles", 64'(tiles), 64'(0));
    check("reset_irq", 64'(irq), 64'(0));

    // Three pushes then three pops
    push(8'h1C); push(8'h32); push(8'h21);
    check_status("push3_status", 3, 0);
    check("push3_status_lit", 64'(bus.rd), 64'h0301);
    pop(d); check("pop_1c", 64'(d), 64'h1C);
    pop(d); check("pop_32", 64'(d), 64'h32);
    pop(d); check("pop_21", 64'(d), 64'h21);
    check_status("pop3_status", 0, 0);

    // Empty read: zero, no state change
    pop(d); check("empty_read", 64'(d), 64'h0);
    check_status("empty_read_status", 0, 0);

    // Overflow: nine pushes into eight entries
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    check_status("ovf_status", 8, 1);
    wr_reg(BASE + 32'h8, 32'h1);
    check_status("ovf_clear_status", 8, 0);
    for (int i = 0; i < 8; i++) begin
      pop(d);
      check($sformatf("ovf_pop%0d", i), 64'(d), 64'(8'h10 + i));
    end
    check_status("ovf_drained", 0, 0);

    // Simultaneous push and pop with count=2
    push(8'hAA); push(8'hBB);
    kb_valid = 1'b1; kb_data = 8'h55;
    pop(d);
    kb_valid = 1'b0;
    check("pp_head", 64'(d), 64'hAA);
    check_status("pp_count", 2, 0);
    pop(d); check("pp_bb", 64'(d), 64'hBB);
    pop(d); check("pp_55", 64'(d), 64'h55);

    // Simultaneous push and pop when full: no overflow
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    kb_valid = 1'b1; kb_data = 8'h77;
    pop(d);
    kb_valid = 1'b0;
    check("full_pp_head", 64'(d), 64'h60);
    check_status("full_pp_status", 8, 0);

    // Flush, then flush racing a push
    wr_reg(BASE + 32'h8, 32'h2);
    check_status("flush_status", 0, 0);
    push(8'h01);
    kb_valid = 1'b1; kb_data = 8'h02;
    wr_reg(BASE + 32'h8, 32'h2);
    kb_valid = 1'b0;
    check_status("flush_push_status", 0, 0);
    rd_reg(BASE + 32'h8, d);
    check("ctrl_selfclear", 64'(d), 64'h0);

    // Overflow clear racing an overflowing push
    for (int i = 0; i < 8; i++) push(8'(i));
    kb_valid = 1'b1; kb_data = 8'hEE;
    wr_reg(BASE + 32'h8, 32'h1);
    kb_valid = 1'b0;
    check_status("clr_vs_ovf", 8, 1);
    wr_reg(BASE + 32'h8, 32'h3);
    check_status("flush_clr", 0, 0);

    // Tiles
    wr_reg(BASE + 32'h14, 32'hFFFF_FABC);
    check("tile1_out", 64'(tiles[25:13]), 64'h1ABC);
    rd_reg(BASE + 32'h14, d);
    check("tile1_rd", 64'(d), 64'h0000_1ABC);
    bus.addr = BASE + 32'h10 + 32'(4 * NT);
    #1;
    check("past_tiles_hit", 64'(bus.hit), 64'(0));
    wr_reg(BASE + 32'h10 + 32'(4 * NT), 32'h0000_0FFF);
    check("past_tiles_nochg", 64'(tiles), 64'(13'h1ABC) << 13);
    wr_reg(BASE + 32'h13, 32'h0000_0123);
    check("tile0_lowbits", 64'(tiles), (64'(13'h1ABC) << 13) | 64'h123);
    bus.addr = BASE + 32'h1C; #1;
    check("last_tile_hit", 64'(bus.hit), 64'(1));
    bus.addr = BASE - 32'h4; #1;
    check("below_base_hit", 64'(bus.hit), 64'(0));
    wr_reg(BASE, 32'hFFFF_FFFF);
    check_status("status_write_ignored", 0, 0);
    check("status_write_tiles", 64'(tiles), (64'(13'h1ABC) << 13) | 64'h123);

`ifdef MMIO_HUB_IRQ_EN
    wr_reg(BASE + 32'h8, 32'h4);
    rd_reg(BASE + 32'h8, d);
    check("irq_en_rd", 64'(d), 64'h4);
    push(8'h5A);
    check("irq_lag", 64'(irq), 64'(0));
    tick();
    check("irq_set", 64'(irq), 64'(1));
    pop(d);
    check("irq_pop_data", 64'(d), 64'h5A);
    tick();
    check("irq_clear", 64'(irq), 64'(0));
    kb_valid = 1'b1; kb_data = 8'h33;
    wr_reg(BASE + 32'h8, 32'h2);
    kb_valid = 1'b0;
    check_status("irq_flush_push", 0, 0);
    wr_reg(BASE + 32'h8, 32'h4);
`endif

    // Reset mid-stream with count=5 and overflow=1
    for (int i = 0; i < 9; i++) push(8'(8'h40 + i));
    for (int i = 0; i < 3; i++) pop(d);
    check_status("pre_reset_status", 5, 1);
    reset    = 1'b1;
    kb_valid = 1'b1; kb_data = 8'h99;
    bus.addr = BASE + 32'h10; bus.wd = 32'h0000_0555; bus.we = 1'b1;
    tick();
    reset = 1'b0; kb_valid = 1'b0; bus.we = 1'b0;
    check_status("post_reset_status", 0, 0);
    check("post_reset_tiles", 64'(tiles), 64'(0));
    check("post_reset_irq", 64'(irq), 64'(0));
    rd_reg(BASE + 32'h8, d);
    check("post_reset_ctrl", 64'(d), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
